// File: rtl/sram_stage_sequencer.sv
// Runs the enabled processing stages one after another in ascending index order,
// giving the stage that currently owns the shared SRAM port its raddr/waddr/wdata/wr_enable.

module sram_stage_slice #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          grant,
    input  logic [AW-1:0] raddr,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wr_enable,
    output logic [AW-1:0] gated_raddr,
    output logic [AW-1:0] gated_waddr,
    output logic [DW-1:0] gated_wdata,
    output logic          gated_wr_enable
);
    assign gated_raddr     = grant ? raddr : '0;
    assign gated_waddr     = grant ? waddr : '0;
    assign gated_wdata     = grant ? wdata : '0;
    assign gated_wr_enable = grant & wr_enable;
endmodule

module sram_stage_sequencer #(
    parameter int AW             = 18,
    parameter int DW             = 16,
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SW             = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_STAGES-1:0]    stage_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [SW-1:0]            cur_stage,
    output logic [NUM_STAGES-1:0]    stg_start,
    input  logic [NUM_STAGES-1:0]    stg_done,
    input  logic [NUM_STAGES*AW-1:0] stg_raddr,
    input  logic [NUM_STAGES*AW-1:0] stg_waddr,
    input  logic [NUM_STAGES*DW-1:0] stg_wdata,
    input  logic [NUM_STAGES-1:0]    stg_wr_enable,
    output logic [AW-1:0]            sram_raddr,
    output logic [AW-1:0]            sram_waddr,
    output logic [DW-1:0]            sram_wdata,
    output logic                     sram_wr_enable
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

    // Timeout fires on the RUN cycle whose count equals TIMEOUT_CYCLES-1,
    // i.e. after exactly TIMEOUT_CYCLES RUN cycles without stg_done.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam bit          TO_ON   = (TIMEOUT_CYCLES > 0);

    state_t                  state, state_nx;
    logic [NUM_STAGES-1:0]   mask, mask_nx;
    logic [31:0]             cnt, cnt_nx;
    logic [SW-1:0]           cur_nx;
    logic                    to_nx;

    logic [NUM_STAGES-1:0]   sel, grant;
    logic                    cur_done, to_hit, mux_on;
    logic [SW-1:0]           first_idx, next_idx;
    logic                    first_any, next_any;

    logic [NUM_STAGES-1:0][AW-1:0] raddr_a, waddr_a, g_raddr, g_waddr;
    logic [NUM_STAGES-1:0][DW-1:0] wdata_a, g_wdata;
    logic [NUM_STAGES-1:0]         g_we;

    assign mux_on = ((state == S_LAUNCH) || (state == S_RUN)) && !abort;

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            assign sel[k]     = (cur_stage == SW'(k));
            assign grant[k]   = sel[k] & mux_on;
            assign raddr_a[k] = stg_raddr[k*AW +: AW];
            assign waddr_a[k] = stg_waddr[k*AW +: AW];
            assign wdata_a[k] = stg_wdata[k*DW +: DW];

            sram_stage_slice #(.AW(AW), .DW(DW)) u_slice (
                .grant           (grant[k]),
                .raddr           (raddr_a[k]),
                .waddr           (waddr_a[k]),
                .wdata           (wdata_a[k]),
                .wr_enable       (stg_wr_enable[k]),
                .gated_raddr     (g_raddr[k]),
                .gated_waddr     (g_waddr[k]),
                .gated_wdata     (g_wdata[k]),
                .gated_wr_enable (g_we[k])
            );
        end
    endgenerate

    // At most one grant bit is set, so OR-reduction is the mux.
    always_comb begin
        sram_raddr     = '0;
        sram_waddr     = '0;
        sram_wdata     = '0;
        sram_wr_enable = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            sram_raddr     = sram_raddr | g_raddr[k];
            sram_waddr     = sram_waddr | g_waddr[k];
            sram_wdata     = sram_wdata | g_wdata[k];
            sram_wr_enable = sram_wr_enable | g_we[k];
        end
    end

    // Downward scans leave the lowest qualifying index in place.
    always_comb begin
        first_idx = '0;
        first_any = 1'b0;
        next_idx  = '0;
        next_any  = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_enable[k]) begin
                first_idx = SW'(k);
                first_any = 1'b1;
            end
            if (mask[k] && (SW'(k) > cur_stage)) begin
                next_idx = SW'(k);
                next_any = 1'b1;
            end
        end
    end

    assign cur_done = |(stg_done & sel);
    assign to_hit   = TO_ON && (cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        cnt_nx   = cnt;
        cur_nx   = cur_stage;
        to_nx    = timeout_err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mask_nx = stage_enable;
                    to_nx   = 1'b0;
                    cnt_nx  = '0;
                    if (first_any) begin
                        cur_nx   = first_idx;
                        state_nx = S_LAUNCH;
                    end else begin
                        state_nx = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_nx   = '0;
                state_nx = S_RUN;
            end
            S_RUN: begin
                if (cur_done) begin
                    if (next_any) begin
                        cur_nx   = next_idx;
                        state_nx = S_LAUNCH;
                    end else begin
                        state_nx = S_FINISH;
                    end
                end else if (to_hit) begin
                    to_nx    = 1'b1;
                    cur_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end
            S_FINISH: begin
                cur_nx   = '0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort outranks both stage completion and timeout.
        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            cur_nx   = '0;
            cnt_nx   = cnt;
            to_nx    = timeout_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mask        <= '0;
            cnt         <= '0;
            cur_stage   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            mask        <= mask_nx;
            cnt         <= cnt_nx;
            cur_stage   <= cur_nx;
            timeout_err <= to_nx;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH) && !abort;
    assign stg_start = (state == S_LAUNCH) ? sel : '0;
endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed scoreboard bench: stimulus queues expected pulses and state snapshots,
// a negedge monitor checks them against the sequencer.

module tb_sram_stage_sequencer;
    localparam int AW = 18, DW = 16, NS = 4, TO = 20, SW = 3;
    localparam int K_START = 0, K_DONE = 1, K_TO = 2;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [NS-1:0]     stage_enable;
    logic              busy, done, timeout_err;
    logic [SW-1:0]     cur_stage;
    logic [NS-1:0]     stg_start, stg_done, eng_done, inj_done, hang;
    logic [NS*AW-1:0]  stg_raddr, stg_waddr;
    logic [NS*DW-1:0]  stg_wdata;
    logic [NS-1:0]     stg_wr_enable;
    logic [AW-1:0]     sram_raddr, sram_waddr;
    logic [DW-1:0]     sram_wdata;
    logic              sram_wr_enable;

    int cyc = 0;
    int n_vec = 0, n_bad = 0;
    bit mon_en = 0, fin = 0;

    typedef struct { int cyc; int kind; logic [NS-1:0] val; } ev_t;
    typedef struct { int cyc; logic busy; logic to; logic [SW-1:0] stage; logic mux; } pr_t;
    ev_t ev_q[$];
    pr_t pr_q[$];

    assign stg_done = eng_done | inj_done;

    sram_stage_sequencer #(.AW(AW), .DW(DW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .SW(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stage_enable(stage_enable),
        .busy(busy), .done(done), .timeout_err(timeout_err), .cur_stage(cur_stage),
        .stg_start(stg_start), .stg_done(stg_done), .stg_raddr(stg_raddr), .stg_waddr(stg_waddr),
        .stg_wdata(stg_wdata), .stg_wr_enable(stg_wr_enable), .sram_raddr(sram_raddr),
        .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_wr_enable(sram_wr_enable)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] ra(int k); return 18'h01000 + AW'(k); endfunction
    function automatic logic [AW-1:0] wa(int k); return 18'h20A00 + AW'(k * 16); endfunction
    function automatic logic [DW-1:0] wd(int k); return 16'hA500 + DW'(k * 257); endfunction
    function automatic logic we(int k); return (k % 2) == 1; endfunction

    task automatic step(); @(posedge clk); #1; endtask
    task automatic run_to(input int n); while (cyc < n) step(); endtask
    task automatic exp_ev(input int c, input int kind, input logic [NS-1:0] v);
        ev_t e; e.cyc = c; e.kind = kind; e.val = v; ev_q.push_back(e);
    endtask
    task automatic probe(input int c, input logic b, input logic t, input int s, input logic m);
        pr_t p; p.cyc = c; p.busy = b; p.to = t; p.stage = SW'(s); p.mux = m; pr_q.push_back(p);
    endtask
    task automatic p_idle(input int c, input logic t); probe(c, 1'b0, t, 0, 1'b0); endtask
    task automatic p_run(input int c, input int s);    probe(c, 1'b1, 1'b0, s, 1'b1); endtask
    task automatic go(input logic [NS-1:0] m, input logic ab, output int t);
        t = cyc; start = 1'b1; stage_enable = m; abort = ab;
        step();
        start = 1'b0; abort = 1'b0; stage_enable = '0;
    endtask

    // Stage engines: done pulse 10 cycles after their start unless hung.
    initial begin
        int cnt_e[NS];
        for (int k = 0; k < NS; k++) cnt_e[k] = 0;
        eng_done = '0;
        forever begin
            step();
            eng_done = '0;
            for (int k = 0; k < NS; k++) begin
                if (cnt_e[k] != 0) begin
                    cnt_e[k]--;
                    if (cnt_e[k] == 0 && !hang[k]) eng_done[k] = 1'b1;
                end
                if (stg_start[k]) cnt_e[k] = 10;
            end
        end
    end

    task automatic check_ev(input int kind, input logic [NS-1:0] v);
        ev_t e;
        n_vec++;
        if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
            n_bad++;
            $display("FAIL unexpected_event cyc=%0d: got kind=%0d val=%b, required none", cyc, kind, v);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind || e.val != v) begin
                n_bad++;
                $display("FAIL event cyc=%0d: got kind=%0d val=%b, required kind=%0d val=%b",
                         cyc, kind, v, e.kind, e.val);
            end
        end
    endtask

    initial begin
        logic to_prev;
        pr_t p;
        logic [62:0] act, expv;
        int k;
        to_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    n_vec++; n_bad++;
                    $display("FAIL missed_event kind=%0d val=%b: not seen, required at cyc=%0d",
                             ev_q[0].kind, ev_q[0].val, ev_q[0].cyc);
                    void'(ev_q.pop_front());
                end
                if (stg_start != '0) check_ev(K_START, stg_start);
                if (done) check_ev(K_DONE, '0);
                if (timeout_err && !to_prev) check_ev(K_TO, '0);
                while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
                    p = pr_q.pop_front();
                    if (p.cyc == cyc) begin
                        k = int'(p.stage);
                        act  = {busy, done, timeout_err, stg_start, cur_stage,
                                sram_raddr, sram_waddr, sram_wdata, sram_wr_enable};
                        expv = {p.busy, 1'b0, p.to, 4'b0, p.stage,
                                p.mux ? {ra(k), wa(k), wd(k), we(k)} : 53'b0};
                        n_vec++;
                        if (act !== expv) begin
                            n_bad++;
                            $display("FAIL snapshot cyc=%0d: got %h, required %h", cyc, act, expv);
                        end
                    end
                end
                to_prev = timeout_err;
                if (fin) begin
                    n_vec++;
                    if (ev_q.size() != 0 || pr_q.size() != 0) begin
                        n_bad++;
                        $display("FAIL leftover: got %0d events %0d probes pending, required 0 0",
                                 ev_q.size(), pr_q.size());
                    end
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                    $finish;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; abort = 1'b0; stage_enable = '0;
        inj_done = '0; hang = '0;
        for (int k = 0; k < NS; k++) begin
            stg_raddr[k*AW +: AW] = ra(k);
            stg_waddr[k*AW +: AW] = wa(k);
            stg_wdata[k*DW +: DW] = wd(k);
            stg_wr_enable[k]      = we(k);
        end
        step();
        mon_en = 1'b1;
        p_idle(cyc + 1, 1'b0);
        step(); step();
        reset = 1'b0;
        p_idle(cyc + 1, 1'b0);
        run_to(6);

        // all four stages, 10-cycle engines
        go(4'b1111, 1'b0, t);
        exp_ev(t + 1, K_START, 4'b0001); exp_ev(t + 12, K_START, 4'b0010);
        exp_ev(t + 23, K_START, 4'b0100); exp_ev(t + 34, K_START, 4'b1000);
        exp_ev(t + 45, K_DONE, '0);
        p_run(t + 5, 0); p_run(t + 16, 1); p_run(t + 27, 2); p_run(t + 38, 3);
        p_idle(t + 46, 1'b0);
        run_to(t + 50);

        // sparse mask, stray stg_done[0], start while busy
        go(4'b1010, 1'b0, t);
        exp_ev(t + 1, K_START, 4'b0010); exp_ev(t + 12, K_START, 4'b1000);
        exp_ev(t + 23, K_DONE, '0);
        p_run(t + 6, 1); p_run(t + 15, 3); p_idle(t + 24, 1'b0);
        run_to(t + 5);
        inj_done = 4'b0001; step(); inj_done = '0;
        run_to(t + 8);
        start = 1'b1; stage_enable = 4'b1111; step(); start = 1'b0; stage_enable = '0;
        run_to(t + 28);

        // empty mask
        go(4'b0000, 1'b0, t);
        exp_ev(t + 1, K_DONE, '0);
        p_idle(t + 2, 1'b0);
        run_to(t + 5);

        // stage 2 hangs -> timeout after 20 RUN cycles
        hang = 4'b0100;
        go(4'b0110, 1'b0, t);
        exp_ev(t + 1, K_START, 4'b0010); exp_ev(t + 12, K_START, 4'b0100);
        exp_ev(t + 33, K_TO, '0);
        p_run(t + 32, 2); p_idle(t + 33, 1'b1); p_idle(t + 36, 1'b1);
        run_to(t + 38);
        hang = '0;

        // next start clears timeout_err; abort in IDLE ignored
        p_idle(cyc, 1'b1);
        go(4'b0001, 1'b1, t);
        exp_ev(t + 1, K_START, 4'b0001); exp_ev(t + 12, K_DONE, '0);
        p_run(t + 2, 0); p_idle(t + 13, 1'b0);
        run_to(t + 16);

        // abort coincident with stg_done[1]
        go(4'b0111, 1'b0, t);
        exp_ev(t + 1, K_START, 4'b0001); exp_ev(t + 12, K_START, 4'b0010);
        p_run(t + 15, 1);
        probe(t + 22, 1'b1, 1'b0, 1, 1'b0);
        p_idle(t + 23, 1'b0); p_idle(t + 30, 1'b0);
        run_to(t + 22);
        abort = 1'b1; step(); abort = 1'b0;
        run_to(t + 32);

        // reset mid-RUN, with a simultaneous start
        go(4'b1111, 1'b0, t);
        exp_ev(t + 1, K_START, 4'b0001);
        p_run(t + 3, 0); p_idle(t + 6, 1'b0); p_idle(t + 14, 1'b0);
        run_to(t + 5);
        reset = 1'b1; start = 1'b1; stage_enable = 4'b1111;
        step();
        reset = 1'b0; start = 1'b0; stage_enable = '0;
        run_to(t + 16);

        fin = 1'b1;
        repeat (4) step();
    end
endmodule
